// File: rtl/bt_status_tx_pkg.sv
// Shared frame layout, FSM encoding and payload snapshot for the status transmitter.
package bt_status_tx_pkg;

  localparam int FRAME_LEN = 7;

  localparam logic [2:0] IDX_HDR   = 3'd0;
  localparam logic [2:0] IDX_SONG  = 3'd1;
  localparam logic [2:0] IDX_VOL   = 3'd2;
  localparam logic [2:0] IDX_FLAGS = 3'd3;
  localparam logic [2:0] IDX_MIN   = 3'd4;
  localparam logic [2:0] IDX_SEC   = 3'd5;
  localparam logic [2:0] IDX_CHK   = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  // Payload values frozen for the duration of one frame.
  typedef struct packed {
    logic [2:0] song;
    logic [3:0] vol;
    logic       fin;
    logic       pause;
    logic [7:0] minute;
    logic [7:0] second;
  } snap_t;

  // Byte at position idx of the frame; the checksum covers bytes 1..5.
  function automatic logic [7:0] frame_byte(snap_t s, logic [2:0] idx, logic [7:0] hdr);
    logic [7:0] b_song, b_vol, b_flags;
    b_song  = {5'b0, s.song};
    b_vol   = {4'b0, s.vol};
    b_flags = {6'b0, s.fin, s.pause};
    case (idx)
      IDX_HDR:   frame_byte = hdr;
      IDX_SONG:  frame_byte = b_song;
      IDX_VOL:   frame_byte = b_vol;
      IDX_FLAGS: frame_byte = b_flags;
      IDX_MIN:   frame_byte = s.minute;
      IDX_SEC:   frame_byte = s.second;
      IDX_CHK:   frame_byte = b_song ^ b_vol ^ b_flags ^ s.minute ^ s.second;
      default:   frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bt_status_tx_uart_tx_byte.sv
// 8N1 byte serializer. Ready is also raised on the last stop-bit cycle so a
// following byte starts its start bit with no idle gap.
module uart_tx_byte #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_done,
  output logic       tx
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic          active;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]    sh;        // remaining data bits followed by the stop bit
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign o_done  = active && bit_end && (bit_idx == 4'd9);
  assign o_ready = !active || o_done;

  // Bit timing and shifting; a new accept takes priority over going idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else if (i_valid && o_ready) begin
      active  <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= {1'b1, i_data};
      tx      <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= sh[0];
          sh      <= {1'b0, sh[8:1]};
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bt_status_tx.sv
// Player status frame transmitter: detects state changes, snapshots the
// payload and sends a 7-byte frame back over the UART line.
module bt_status_tx
  import bt_status_tx_pkg::*;
#(
  parameter int         CLK_HZ = 100_000_000,
  parameter int         BAUD   = 9600,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_song_select,
  input  logic [3:0] i_vol_level,
  input  logic       i_pause,
  input  logic [7:0] i_minute,
  input  logic [7:0] i_second,
  input  logic       i_finish_song,
  output logic       tx,
  output logic       o_busy,
  output logic       o_frame_done
);

  state_t     state;
  logic [2:0] byte_idx;
  snap_t      snap;

  logic [2:0] prev_song;
  logic [3:0] prev_vol;
  logic       prev_pause;
  logic [7:0] prev_second;
  logic       pending, fin_flag;
  logic       change, leave_idle;

  logic       byte_valid, byte_ready, byte_done;
  logic [7:0] byte_data;
  logic [2:0] next_idx;

  // Minute is carried in the frame but is not a trigger on its own.
  assign change = {i_song_select, i_vol_level, i_pause, i_second} !=
                  {prev_song, prev_vol, prev_pause, prev_second};
  assign leave_idle = (state == ST_IDLE) && pending;

  // Change detect and sticky request flags; a set in the clearing cycle wins.
  always_ff @(posedge clk) begin
    prev_song   <= i_song_select;
    prev_vol    <= i_vol_level;
    prev_pause  <= i_pause;
    prev_second <= i_second;
    if (rst) begin
      pending  <= 1'b0;
      fin_flag <= 1'b0;
    end else begin
      pending  <= change | i_finish_song | (pending & ~leave_idle);
      fin_flag <= i_finish_song | (fin_flag & ~leave_idle);
    end
  end

  // Feed the byte engine: header from LOAD, then each next byte right as the previous one ends.
  always_comb begin
    next_idx   = (state == ST_LOAD) ? IDX_HDR : byte_idx + 3'd1;
    byte_data  = frame_byte(snap, next_idx, HEADER);
    byte_valid = byte_ready &&
                 ((state == ST_LOAD) ||
                  ((state == ST_SEND) && byte_done && (byte_idx != IDX_CHK)));
  end

  // Frame sequencer with registered busy/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      byte_idx     <= '0;
      snap         <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (pending) begin
          state  <= ST_LOAD;
          o_busy <= 1'b1;
          snap   <= '{song: i_song_select, vol: i_vol_level, fin: fin_flag,
                      pause: i_pause, minute: i_minute, second: i_second};
        end
        ST_LOAD: begin
          state    <= ST_SEND;
          byte_idx <= IDX_HDR;
        end
        ST_SEND: if (byte_done) begin
          if (byte_idx == IDX_CHK) begin
            state        <= ST_DONE;
            o_frame_done <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 3'd1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_byte (
    .clk     (clk),
    .rst     (rst),
    .i_valid (byte_valid),
    .i_data  (byte_data),
    .o_ready (byte_ready),
    .o_done  (byte_done),
    .tx      (tx)
  );

endmodule
